// File: rtl/axi_lite_order_sequencer.sv
// AXI4-Lite command master: runs a loadable table of WRITE / POLL orders against a register slave.
// Optional ORDER_RESP_CHECK_EN: a non-OKAY bresp/rresp fails the current order.
module axi_lite_order_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ORDER_DEPTH  = 16,
  parameter int unsigned POLL_TIMEOUT = 1024,
  localparam int unsigned IDX_W       = $clog2(ORDER_DEPTH),
  localparam int unsigned STRB_W      = DATA_WIDTH / 8
) (
  input  logic                  system_clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_wr_idx,
  input  logic                  cfg_wr_kind,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic [IDX_W:0]        order_count,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_idx,
  output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic [2:0]            m00_axi_awprot,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  output logic [DATA_WIDTH-1:0] m00_axi_wdata,
  output logic [STRB_W-1:0]     m00_axi_wstrb,
  output logic                  m00_axi_wvalid,
  input  logic                  m00_axi_wready,
  input  logic [1:0]            m00_axi_bresp,
  input  logic                  m00_axi_bvalid,
  output logic                  m00_axi_bready,
  output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0]            m00_axi_arprot,
  output logic                  m00_axi_arvalid,
  input  logic                  m00_axi_arready,
  input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]            m00_axi_rresp,
  input  logic                  m00_axi_rvalid,
  output logic                  m00_axi_rready
);

  localparam int unsigned CNT_W = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_B, S_RD, S_R, S_CHECK, S_NEXT, S_FINISH, S_FAIL
  } state_t;

  state_t                r_state;
  logic                  r_kind_tbl [ORDER_DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr_tbl [ORDER_DEPTH];
  logic [DATA_WIDTH-1:0] r_data_tbl [ORDER_DEPTH];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W:0]        r_count;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]      r_poll_cnt;
  logic                  r_busy, r_done, r_error;
  logic [IDX_W-1:0]      r_err_idx;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic w_idx_ok, w_aw_pend, w_w_pend, w_bresp_bad, w_rresp_bad;

  assign w_idx_ok  = ((IDX_W+1)'(cfg_wr_idx) < (IDX_W+1)'(ORDER_DEPTH));
  assign w_aw_pend = r_awvalid && !m00_axi_awready;
  assign w_w_pend  = r_wvalid && !m00_axi_wready;

`ifdef ORDER_RESP_CHECK_EN
  assign w_bresp_bad = (m00_axi_bresp != 2'b00);
  assign w_rresp_bad = (m00_axi_rresp != 2'b00);
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{m00_axi_bresp, m00_axi_rresp};
  assign w_bresp_bad   = 1'b0;
  assign w_rresp_bad   = 1'b0;
`endif

  // Order table: writable only while idle, frozen during a run
  always_ff @(posedge system_clk) begin
    if (cfg_wr_en && (r_state == S_IDLE) && w_idx_ok) begin
      r_kind_tbl[cfg_wr_idx] <= cfg_wr_kind;
      r_addr_tbl[cfg_wr_idx] <= cfg_wr_addr;
      r_data_tbl[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_mask     <= '0;
      r_rdata    <= '0;
      r_poll_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_idx  <= '0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      // Poll budget covers the whole read/evaluate loop and saturates
      if ((r_state inside {S_RD, S_R, S_CHECK}) && (r_poll_cnt < CNT_W'(POLL_TIMEOUT)))
        r_poll_cnt <= r_poll_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx     <= '0;
            r_count   <= order_count;
            r_err_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= (order_count == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          r_poll_cnt <= '0;
          r_mask     <= r_data_tbl[r_idx];
          if (r_kind_tbl[r_idx]) begin
            r_araddr  <= r_addr_tbl[r_idx];
            r_arvalid <= 1'b1;
            r_state   <= S_RD;
          end else begin
            r_awaddr  <= r_addr_tbl[r_idx];
            r_wdata   <= r_data_tbl[r_idx];
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          // AW and W retire independently, in either order
          if (m00_axi_awready) r_awvalid <= 1'b0;
          if (m00_axi_wready)  r_wvalid  <= 1'b0;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (m00_axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= w_bresp_bad ? S_FAIL : S_NEXT;
          end
        end
        S_RD: begin
          if (m00_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m00_axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m00_axi_rdata;
            r_state  <= w_rresp_bad ? S_FAIL : S_CHECK;
          end
        end
        S_CHECK: begin
          if ((r_rdata & r_mask) == r_mask) begin
            r_state <= S_NEXT;
          end else if (r_poll_cnt >= CNT_W'(POLL_TIMEOUT)) begin
            r_state <= S_FAIL;
          end else begin
            r_arvalid <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_NEXT: begin
          r_idx   <= r_idx + 1'b1;
          r_state <= (((IDX_W+1)'(r_idx) + 1'b1) == r_count) ? S_FINISH : S_FETCH;
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_error   <= 1'b1;
          r_err_idx <= r_idx;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_idx         = r_err_idx;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign m00_axi_araddr  = r_araddr;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = r_arvalid;
  assign m00_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_order_sequencer.sv
// Directed bench for axi_lite_order_sequencer with a configurable-latency AXI4-Lite slave.
module tb_axi_lite_order_sequencer;
  localparam int unsigned AW = 8, DW = 32, DEPTH = 16, IW = 4, PT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [IW-1:0] cfg_wr_idx = '0;
  logic          cfg_wr_kind = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [IW:0]   order_count = '0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [IW-1:0] err_idx;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;

  int checks = 0, errors = 0;
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_zero_n = 0, bad_b_idx = -1;
  logic [DW-1:0] r_good = '0;
  int aw_hs = 0, w_hs = 0, b_sent = 0, ar_hs = 0, r_sent = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, hold_viol = 0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [AW-1:0] ar_log[$];

  always #5 clk = ~clk;

  axi_lite_order_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ORDER_DEPTH(DEPTH), .POLL_TIMEOUT(PT)
  ) dut (
    .system_clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_kind(cfg_wr_kind),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .order_count(order_count), .start(start),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  // Slave: decides ready/valid mid-cycle; a ready raised against a held valid commits a handshake
  initial begin : slave
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [AW-1:0] aw_hold = '0, ar_hold = '0;
    logic [DW-1:0] w_hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if (aw_pend && (!awvalid || awaddr !== aw_hold)) hold_viol++;
        if (w_pend && (!wvalid || wdata !== w_hold)) hold_viol++;
        if (ar_pend && (!arvalid || araddr !== ar_hold)) hold_viol++;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        if (awvalid && aw_wait >= aw_delay) begin
          awready = 1; aw_hs++; aw_log.push_back(awaddr); aw_wait = 0;
        end else if (awvalid) begin
          awready = 0; aw_wait++; aw_pend = 1; aw_hold = awaddr;
        end else begin
          awready = 0; aw_wait = 0;
        end
        if (wvalid && w_wait >= w_delay) begin
          wready = 1; w_hs++; w_log.push_back(wdata); w_wait = 0;
        end else if (wvalid) begin
          wready = 0; w_wait++; w_pend = 1; w_hold = wdata;
        end else begin
          wready = 0; w_wait = 0;
        end
        if (bready && b_sent < aw_hs && b_sent < w_hs) begin
          bvalid = 1; bresp = (b_sent == bad_b_idx) ? 2'b10 : 2'b00; b_sent++;
        end else begin
          bvalid = 0; bresp = 2'b00;
        end
        if (arvalid && ar_wait >= ar_delay) begin
          arready = 1; ar_hs++; ar_log.push_back(araddr); ar_wait = 0;
        end else if (arvalid) begin
          arready = 0; ar_wait++; ar_pend = 1; ar_hold = araddr;
        end else begin
          arready = 0; ar_wait = 0;
        end
        if (rready && r_sent < ar_hs) begin
          rvalid = 1; rdata = (r_sent < r_zero_n) ? '0 : r_good; rresp = 2'b00; r_sent++;
        end else begin
          rvalid = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_zero_n = 0; r_good = '0; bad_b_idx = -1;
    aw_hs = 0; w_hs = 0; b_sent = 0; ar_hs = 0; r_sent = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0; hold_viol = 0;
    aw_log.delete(); w_log.delete(); ar_log.delete();
  endtask

  task automatic load(input int idx, input logic kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_wr_en = 1; cfg_wr_idx = IW'(idx); cfg_wr_kind = kind; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 0;
  endtask

  task automatic run(input int count);
    order_count = (IW+1)'(count); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_end(input int max, output bit got_done, output bit got_err);
    got_done = 0; got_err = 0;
    for (int i = 0; i < max; i++) begin
      if (done) begin got_done = 1; got_err = error; break; end
      if (error) begin got_err = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(2);
    checks++;
    if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000000",
                         {busy, done, error, awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({err_idx, awaddr, araddr, wdata} !== '0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {err_idx, awaddr, araddr, wdata});
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_basic();
    bit gd, ge;
    clear_stats();
    load(0, 0, 8'h00, 32'h1);
    load(1, 0, 8'h08, 32'hAB);
    run(2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_run got %b want 1", busy); end
    wait_end(100, gd, ge);
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL t1_done got done=%b err=%b want 1/0", gd, ge); end
    checks++;
    if (aw_hs != 2 || w_hs != 2) begin errors++; $display("FAIL t1_beats got aw=%0d w=%0d want 2/2", aw_hs, w_hs); end
    checks++;
    if (aw_log.size() != 2 || aw_log[0] !== 8'h00 || aw_log[1] !== 8'h08) begin
      errors++; $display("FAIL t1_awaddr got %p want 00,08", aw_log);
    end
    checks++;
    if (w_log.size() != 2 || w_log[0] !== 32'h1 || w_log[1] !== 32'hAB) begin
      errors++; $display("FAIL t1_wdata got %p want 1,ab", w_log);
    end
    checks++;
    if (wstrb !== 4'hF || awprot !== 3'b000 || arprot !== 3'b000) begin
      errors++; $display("FAIL t1_strb_prot got %h/%b/%b want f/000/000", wstrb, awprot, arprot);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t1_after got busy=%b done=%b want 0/0", busy, done); end
    checks++;
    if (done_cnt != 1 || both_cnt != 0) begin errors++; $display("FAIL t1_pulses got %0d/%0d want 1/0", done_cnt, both_cnt); end
  endtask

  task automatic test_aw_w_skew();
    bit gd, ge;
    for (int pass = 0; pass < 2; pass++) begin
      clear_stats();
      aw_delay = (pass == 0) ? 3 : 0;
      w_delay  = (pass == 0) ? 0 : 3;
      run(2);
      wait_end(200, gd, ge);
      checks++;
      if (gd !== 1'b1 || aw_hs != 2 || w_hs != 2) begin
        errors++; $display("FAIL t2_skew%0d got done=%b aw=%0d w=%0d want 1/2/2", pass, gd, aw_hs, w_hs);
      end
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL t2_hold%0d got %0d want 0", pass, hold_viol); end
      tick();
    end
  endtask

  task automatic test_poll_ok();
    bit gd, ge;
    clear_stats();
    r_zero_n = 4; r_good = 32'h3;
    load(0, 1, 8'h04, 32'h2);
    run(1);
    wait_end(300, gd, ge);
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL t3_done got done=%b err=%b want 1/0", gd, ge); end
    checks++;
    if (ar_hs != 5 || aw_hs != 0) begin errors++; $display("FAIL t3_reads got ar=%0d aw=%0d want 5/0", ar_hs, aw_hs); end
    checks++;
    if (ar_log.size() == 0 || ar_log[0] !== 8'h04) begin errors++; $display("FAIL t3_araddr got %p want 04", ar_log); end
    tick();
  endtask

  task automatic test_poll_timeout();
    bit gd, ge;
    clear_stats();
    r_zero_n = 100000;
    run(1);
    wait_end(500, gd, ge);
    checks++;
    if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL t4_error got err=%b done=%b want 1/0", ge, gd); end
    checks++;
    if (err_idx !== 4'd0) begin errors++; $display("FAIL t4_err_idx got %0d want 0", err_idx); end
    tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != 0 || hold_viol != 0) begin
      errors++; $display("FAIL t4_idle got busy=%b done_cnt=%0d hv=%0d want 0/0/0", busy, done_cnt, hold_viol);
    end
  endtask

  task automatic test_bresp();
    bit gd, ge;
    clear_stats();
    bad_b_idx = 1;
    load(0, 0, 8'h10, 32'h11);
    load(1, 0, 8'h14, 32'h22);
    load(2, 0, 8'h18, 32'h33);
    run(3);
    wait_end(200, gd, ge);
`ifdef ORDER_RESP_CHECK_EN
    checks++;
    if (ge !== 1'b1 || gd !== 1'b0 || err_idx !== 4'd1) begin
      errors++; $display("FAIL t5_bresp got err=%b done=%b idx=%0d want 1/0/1", ge, gd, err_idx);
    end
    checks++;
    if (aw_hs != 2) begin errors++; $display("FAIL t5_issued got %0d want 2", aw_hs); end
`else
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL t5_done got done=%b err=%b want 1/0", gd, ge); end
    checks++;
    if (aw_hs != 3 || aw_log.size() != 3 || aw_log[2] !== 8'h18) begin
      errors++; $display("FAIL t5_issued got %0d %p want 3 ending 18", aw_hs, aw_log);
    end
`endif
    tick();
  endtask

  task automatic test_zero_count();
    clear_stats();
    order_count = '0; start = 1;
    tick();
    start = 0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t6_zero_c1 got done=%b busy=%b want 0/1", done, busy); end
    tick();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL t6_zero_c2 got done=%b err=%b want 1/0", done, error); end
    checks++;
    if (aw_hs != 0 || ar_hs != 0) begin errors++; $display("FAIL t6_zero_axi got aw=%0d ar=%0d want 0/0", aw_hs, ar_hs); end
    tick();
  endtask

  task automatic test_busy_ignore();
    bit gd, ge;
    clear_stats();
    load(0, 0, 8'h20, 32'h5);
    load(1, 0, 8'h24, 32'h6);
    aw_delay = 6;
    run(2);
    tick(2);
    cfg_wr_en = 1; cfg_wr_idx = '0; cfg_wr_kind = 1; cfg_wr_addr = 8'h40; cfg_wr_data = 32'h1;
    start = 1; order_count = 5'd1;
    tick();
    cfg_wr_en = 0; start = 0;
    wait_end(300, gd, ge);
    checks++;
    if (gd !== 1'b1 || aw_hs != 2 || w_hs != 2) begin
      errors++; $display("FAIL t6_busy_run got done=%b aw=%0d w=%0d want 1/2/2", gd, aw_hs, w_hs);
    end
    tick();
    clear_stats();
    r_good = 32'h1;
    run(1);
    wait_end(100, gd, ge);
    checks++;
    if (gd !== 1'b1 || aw_hs != 1 || ar_hs != 0 || aw_log.size() != 1 || aw_log[0] !== 8'h20) begin
      errors++; $display("FAIL t6_frozen got done=%b aw=%0d ar=%0d log=%p want 1/1/0/20", gd, aw_hs, ar_hs, aw_log);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    clear_stats();
    load(0, 0, 8'h30, 32'h77);
    aw_delay = 50; w_delay = 50;
    run(1);
    tick(2);
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 8'h30) begin
      errors++; $display("FAIL t6_pre_rst got awv=%b wv=%b addr=%h want 1/1/30", awvalid, wvalid, awaddr);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00 ||
        awaddr !== '0 || wdata !== '0) begin
      errors++; $display("FAIL t6_rst_mid got ctrl=%b addr=%h data=%h want 0/0/0",
                         {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, awaddr, wdata);
    end
    tick(2);
    rst_n = 1;
    clear_stats();
    tick();
  endtask

  initial begin : main
    test_reset();
    test_write_basic();
    test_aw_w_skew();
    test_poll_ok();
    test_poll_timeout();
    test_bresp();
    test_zero_count();
    test_busy_ignore();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
